// File: rtl/atm_keypad_entry_if.sv
// Signal bundle between the keypad source, the keypad entry front-end and the
// authentication stage. The entry block is the slave, and its environment is the master.
interface atm_keypad_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        out_ready;
    logic        auth_done;
    logic        auth_ok;
    logic [11:0] accNumber;
    logic [3:0]  pin;
    logic        out_valid;
    logic        key_err;
    logic        timeout;
    logic        locked;
    logic [1:0]  fail_cnt;

    modport master (
        output key_valid, key_code, out_ready, auth_done, auth_ok,
        input  accNumber, pin, out_valid, key_err, timeout, locked, fail_cnt
    );

    modport slave (
        input  key_valid, key_code, out_ready, auth_done, auth_ok,
        output accNumber, pin, out_valid, key_err, timeout, locked, fail_cnt
    );
endinterface

// File: rtl/atm_keypad_entry.sv
// ATM keypad front-end: assembles an account number and a PIN from key events,
// presents the credential and tracks auth failures, lockout and inactivity.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ACC   | collecting account digits
// ST_PIN   | collecting the single PIN digit
// ST_PRES  | credential presented, waiting for out_ready
// ST_WAIT  | credential handed off, waiting for the auth verdict
// ST_LOCK  | too many consecutive failures; only reset leaves this state
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_FAILS      = 3,
    parameter int ACC_DIGITS     = 4
) (
    input logic               clk,
    input logic               reset_n,
    atm_keypad_entry_if.slave bus
);
    localparam int CNT_W  = $clog2(ACC_DIGITS + 1);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LOAD  = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(ACC_DIGITS);
    localparam logic [2:0]        FAIL_LIMIT = 3'(MAX_FAILS);

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {
        ST_ACC  = 3'd0,
        ST_PIN  = 3'd1,
        ST_PRES = 3'd2,
        ST_WAIT = 3'd3,
        ST_LOCK = 3'd4
    } state_t;

    state_t            state;
    logic [11:0]       acc_r;
    logic [3:0]        pin_r;
    logic              pin_set;
    logic [CNT_W-1:0]  digit_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              out_valid_r;
    logic              key_err_r;
    logic              timeout_r;
    logic              locked_r;
    logic [1:0]        fail_cnt_r;

    logic        key_digit;
    logic        key_legal;
    logic [15:0] acc_next;
    logic        acc_fits;
    logic [2:0]  fail_next;
    logic        idle_run;
    logic        idle_expire;

    assign key_digit   = (bus.key_code <= 4'd9);
    assign key_legal   = (bus.key_code <= KEY_CANCEL);
    // Widened so an overflowing fifth digit or 4096 is caught by the compare.
    assign acc_next    = ({4'd0, acc_r} * 16'd10) + {12'd0, bus.key_code};
    assign acc_fits    = (acc_next <= 16'd4095);
    assign fail_next   = {1'b0, fail_cnt_r} + 3'd1;
    assign idle_run    = ((state == ST_ACC) && (digit_cnt != '0)) || (state == ST_PIN);
    assign idle_expire = idle_run && !bus.key_valid && (idle_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_ACC;
            acc_r       <= '0;
            pin_r       <= '0;
            pin_set     <= 1'b0;
            digit_cnt   <= '0;
            idle_cnt    <= IDLE_LOAD;
            out_valid_r <= 1'b0;
            key_err_r   <= 1'b0;
            timeout_r   <= 1'b0;
            locked_r    <= 1'b0;
            fail_cnt_r  <= '0;
        end else begin
            key_err_r <= 1'b0;
            timeout_r <= 1'b0;

            // Down-counter reloads whenever it is not running or a key arrives.
            if (!idle_run || bus.key_valid)
                idle_cnt <= IDLE_LOAD;
            else if (idle_cnt != '0)
                idle_cnt <= idle_cnt - 1'b1;

            if (idle_expire) begin
                timeout_r <= 1'b1;
                acc_r     <= '0;
                pin_r     <= '0;
                pin_set   <= 1'b0;
                digit_cnt <= '0;
                state     <= ST_ACC;
            end else if (bus.key_valid) begin
                if (!key_legal) begin
                    key_err_r <= 1'b1;
                end else begin
                    case (state)
                        ST_ACC: begin
                            if (key_digit) begin
                                if ((digit_cnt < CNT_MAX) && acc_fits) begin
                                    acc_r     <= acc_next[11:0];
                                    digit_cnt <= digit_cnt + 1'b1;
                                end else begin
                                    key_err_r <= 1'b1;
                                end
                            end else if (bus.key_code == KEY_ENTER) begin
                                if (digit_cnt == '0)
                                    key_err_r <= 1'b1;
                                else
                                    state <= ST_PIN;
                            end else begin
                                acc_r     <= '0;
                                digit_cnt <= '0;
                            end
                        end
                        ST_PIN: begin
                            if (key_digit) begin
                                if (pin_set) begin
                                    key_err_r <= 1'b1;
                                end else begin
                                    pin_r   <= bus.key_code;
                                    pin_set <= 1'b1;
                                end
                            end else if (bus.key_code == KEY_CLEAR) begin
                                pin_r   <= '0;
                                pin_set <= 1'b0;
                            end else if (bus.key_code == KEY_ENTER) begin
                                if (!pin_set) begin
                                    key_err_r <= 1'b1;
                                end else begin
                                    out_valid_r <= 1'b1;
                                    state       <= ST_PRES;
                                end
                            end else begin
                                acc_r     <= '0;
                                pin_r     <= '0;
                                pin_set   <= 1'b0;
                                digit_cnt <= '0;
                                state     <= ST_ACC;
                            end
                        end
                        default: key_err_r <= 1'b1;
                    endcase
                end
            end

            // Handshake and verdict are independent of key handling; keys in
            // these states only raise key_err.
            if ((state == ST_PRES) && out_valid_r && bus.out_ready) begin
                out_valid_r <= 1'b0;
                state       <= ST_WAIT;
            end

            if ((state == ST_WAIT) && bus.auth_done) begin
                if (bus.auth_ok) begin
                    fail_cnt_r <= '0;
                    acc_r      <= '0;
                    pin_r      <= '0;
                    pin_set    <= 1'b0;
                    digit_cnt  <= '0;
                    state      <= ST_ACC;
                end else if (fail_next < FAIL_LIMIT) begin
                    fail_cnt_r <= fail_next[1:0];
                    pin_r      <= '0;
                    pin_set    <= 1'b0;
                    state      <= ST_PIN;
                end else begin
                    fail_cnt_r <= fail_next[1:0];
                    locked_r   <= 1'b1;
                    state      <= ST_LOCK;
                end
            end
        end
    end

    assign bus.accNumber = acc_r;
    assign bus.pin       = pin_r;
    assign bus.out_valid = out_valid_r;
    assign bus.key_err   = key_err_r;
    assign bus.timeout   = timeout_r;
    assign bus.locked    = locked_r;
    assign bus.fail_cnt  = fail_cnt_r;
endmodule

// File: tb/tb_atm_keypad_entry.sv
// Bench for atm_keypad_entry: a vector table with hand-derived expectations,
// followed by hand-written inactivity sequences, all checked through a scoreboard queue.
module tb_atm_keypad_entry;
    localparam int T = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    atm_keypad_entry_if bus ();

    atm_keypad_entry #(
        .TIMEOUT_CYCLES(T),
        .MAX_FAILS(3),
        .ACC_DIGITS(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        string      name;
        bit         rst;
        bit         kv;
        logic [3:0] kc;
        bit         rdy;
        bit         ad;
        bit         aok;
        int         acc;
        int         pin;
        bit         ov;
        bit         ke;
        bit         tm;
        bit         lk;
        int         fc;
    } vec_t;

    typedef struct {
        string       name;
        logic [21:0] exp;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic void add(string n, bit rst, bit kv, logic [3:0] kc, bit rdy, bit ad, bit aok,
                                int acc, int pin, bit ov, bit ke, bit tm, bit lk, int fc);
        vec_t v;
        v.name = n; v.rst = rst; v.kv = kv; v.kc = kc; v.rdy = rdy; v.ad = ad; v.aok = aok;
        v.acc = acc; v.pin = pin; v.ov = ov; v.ke = ke; v.tm = tm; v.lk = lk; v.fc = fc;
        vecs.push_back(v);
    endfunction

    function automatic void k(string n, logic [3:0] kc, int acc, int pin, bit ov, bit ke, int fc, bit lk);
        add(n, 1'b0, 1'b1, kc, 1'b0, 1'b0, 1'b0, acc, pin, ov, ke, 1'b0, lk, fc);
    endfunction

    function automatic void idle(string n, bit rdy, int acc, int pin, bit ov, bit tm, int fc, bit lk);
        add(n, 1'b0, 1'b0, 4'h0, rdy, 1'b0, 1'b0, acc, pin, ov, 1'b0, tm, lk, fc);
    endfunction

    function automatic void auth(string n, bit ok, int acc, int pin, int fc, bit lk);
        add(n, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, ok, acc, pin, 1'b0, 1'b0, 1'b0, lk, fc);
    endfunction

    function automatic void rst(string n);
        add(n, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endfunction

    function automatic logic [21:0] pack_exp(vec_t v);
        return {12'(v.acc), 4'(v.pin), v.ov, v.ke, v.tm, v.lk, 2'(v.fc)};
    endfunction

    task automatic check_out();
        exp_t e;
        logic [21:0] act;
        act = {bus.accNumber, bus.pin, bus.out_valid, bus.key_err, bus.timeout, bus.locked, bus.fail_cnt};
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got output with no expectation queued");
        end else begin
            e = sb.pop_front();
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got acc=%0d pin=%0d ov=%b err=%b tmo=%b lck=%b fc=%0d, want acc=%0d pin=%0d ov=%b err=%b tmo=%b lck=%b fc=%0d",
                         e.name, act[21:10], act[9:6], act[5], act[4], act[3], act[2], act[1:0],
                         e.exp[21:10], e.exp[9:6], e.exp[5], e.exp[4], e.exp[3], e.exp[2], e.exp[1:0]);
            end
        end
    endtask

    task automatic run_vec(vec_t v);
        exp_t e;
        reset_n       = !v.rst;
        bus.key_valid = v.kv;
        bus.key_code  = v.kc;
        bus.out_ready = v.rdy;
        bus.auth_done = v.ad;
        bus.auth_ok   = v.aok;
        e.name = v.name;
        e.exp  = pack_exp(v);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.out_ready = 1'b0;
        bus.auth_done = 1'b0;
        bus.auth_ok   = 1'b0;

        rst("reset");
        // Normal login
        k("login_k2", 4'd2, 2, 0, 0, 0, 0, 0);
        k("login_k7", 4'd7, 27, 0, 0, 0, 0, 0);
        k("login_k4", 4'd4, 274, 0, 0, 0, 0, 0);
        k("login_k9", 4'd9, 2749, 0, 0, 0, 0, 0);
        k("login_enter_acc", 4'hB, 2749, 0, 0, 0, 0, 0);
        k("login_pin0", 4'd0, 2749, 0, 0, 0, 0, 0);
        k("login_enter_pin", 4'hB, 2749, 0, 1, 0, 0, 0);
        idle("login_xfer", 1'b1, 2749, 0, 0, 0, 0, 0);
        auth("login_auth_ok", 1'b1, 0, 0, 0, 0);
        k("login_back_in_acc", 4'd5, 5, 0, 0, 0, 0, 0);
        k("login_clear", 4'hA, 0, 0, 0, 0, 0, 0);
        // Width limits
        k("wid_k4", 4'd4, 4, 0, 0, 0, 0, 0);
        k("wid_k0", 4'd0, 40, 0, 0, 0, 0, 0);
        k("wid_k9", 4'd9, 409, 0, 0, 0, 0, 0);
        k("wid_4096", 4'd6, 409, 0, 0, 1, 0, 0);
        idle("wid_err_one_cycle", 1'b0, 409, 0, 0, 0, 0, 0);
        k("wid_clear", 4'hA, 0, 0, 0, 0, 0, 0);
        k("wid_k2", 4'd2, 2, 0, 0, 0, 0, 0);
        k("wid_k1", 4'd1, 21, 0, 0, 0, 0, 0);
        k("wid_k7", 4'd7, 217, 0, 0, 0, 0, 0);
        k("wid_k5", 4'd5, 2175, 0, 0, 0, 0, 0);
        k("wid_fifth_digit", 4'd3, 2175, 0, 0, 1, 0, 0);
        k("wid_cancel", 4'hC, 0, 0, 0, 0, 0, 0);
        // Empty ENTER and illegal codes in ACC
        k("acc_enter_empty", 4'hB, 0, 0, 0, 1, 0, 0);
        k("acc_illegal_E", 4'hE, 0, 0, 0, 1, 0, 0);
        k("acc_k8", 4'd8, 8, 0, 0, 0, 0, 0);
        k("acc_illegal_D", 4'hD, 8, 0, 0, 1, 0, 0);
        k("acc_clear", 4'hA, 0, 0, 0, 0, 0, 0);
        // Backpressure, then a PIN-state timeout keeping fail_cnt
        k("bp_k2", 4'd2, 2, 0, 0, 0, 0, 0);
        k("bp_k1", 4'd1, 21, 0, 0, 0, 0, 0);
        k("bp_k2b", 4'd2, 212, 0, 0, 0, 0, 0);
        k("bp_k5", 4'd5, 2125, 0, 0, 0, 0, 0);
        k("bp_enter_acc", 4'hB, 2125, 0, 0, 0, 0, 0);
        k("bp_pin3", 4'd3, 2125, 3, 0, 0, 0, 0);
        k("bp_enter_pin", 4'hB, 2125, 3, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) idle("bp_hold", 1'b0, 2125, 3, 1, 0, 0, 0);
        add("bp_auth_ignored", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2125, 3, 1, 0, 0, 0, 0);
        k("bp_key_in_present", 4'd1, 2125, 3, 1, 1, 0, 0);
        idle("bp_xfer", 1'b1, 2125, 3, 0, 0, 0, 0);
        k("bp_key_in_wait", 4'd4, 2125, 3, 0, 1, 0, 0);
        auth("bp_auth_fail", 1'b0, 2125, 0, 1, 0);
        for (int i = 0; i < T - 1; i++) idle("pin_idle", 1'b0, 2125, 0, 0, 0, 1, 0);
        idle("pin_timeout", 1'b0, 0, 0, 0, 1, 1, 0);
        idle("pin_timeout_done", 1'b0, 0, 0, 0, 0, 1, 0);
        k("acc_empty_after_tmo", 4'hB, 0, 0, 0, 1, 1, 0);
        rst("reset_before_lock");
        // Lockout
        k("lk_k2", 4'd2, 2, 0, 0, 0, 0, 0);
        k("lk_k1", 4'd1, 21, 0, 0, 0, 0, 0);
        k("lk_k7", 4'd7, 217, 0, 0, 0, 0, 0);
        k("lk_k8", 4'd8, 2178, 0, 0, 0, 0, 0);
        k("lk_enter_acc", 4'hB, 2178, 0, 0, 0, 0, 0);
        k("lk_pin9_a", 4'd9, 2178, 9, 0, 0, 0, 0);
        k("lk_enter_a", 4'hB, 2178, 9, 1, 0, 0, 0);
        idle("lk_xfer_a", 1'b1, 2178, 9, 0, 0, 0, 0);
        auth("lk_fail1", 1'b0, 2178, 0, 1, 0);
        k("lk_pin9_b", 4'd9, 2178, 9, 0, 0, 1, 0);
        k("lk_enter_b", 4'hB, 2178, 9, 1, 0, 1, 0);
        idle("lk_xfer_b", 1'b1, 2178, 9, 0, 0, 1, 0);
        auth("lk_fail2", 1'b0, 2178, 0, 2, 0);
        k("lk_pin9_c", 4'd9, 2178, 9, 0, 0, 2, 0);
        k("lk_enter_c", 4'hB, 2178, 9, 1, 0, 2, 0);
        idle("lk_xfer_c", 1'b1, 2178, 9, 0, 0, 2, 0);
        auth("lk_fail3_locked", 1'b0, 2178, 9, 3, 1);
        k("lk_key_digit", 4'd5, 2178, 9, 0, 1, 3, 1);
        k("lk_key_enter", 4'hB, 2178, 9, 0, 1, 3, 1);
        add("lk_auth_ignored", 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2178, 9, 0, 0, 0, 1, 3);
        rst("lk_reset");
        // Editing
        k("ed_k2", 4'd2, 2, 0, 0, 0, 0, 0);
        k("ed_k9", 4'd9, 29, 0, 0, 0, 0, 0);
        k("ed_clear", 4'hA, 0, 0, 0, 0, 0, 0);
        k("ed_k2b", 4'd2, 2, 0, 0, 0, 0, 0);
        k("ed_k6", 4'd6, 26, 0, 0, 0, 0, 0);
        k("ed_k4", 4'd4, 264, 0, 0, 0, 0, 0);
        k("ed_k7", 4'd7, 2647, 0, 0, 0, 0, 0);
        k("ed_enter", 4'hB, 2647, 0, 0, 0, 0, 0);
        k("ed_cancel_pin", 4'hC, 0, 0, 0, 0, 0, 0);
        k("ed_k3", 4'd3, 3, 0, 0, 0, 0, 0);
        k("ed_enter2", 4'hB, 3, 0, 0, 0, 0, 0);
        k("ed_pin_enter_empty", 4'hB, 3, 0, 0, 1, 0, 0);
        k("ed_pin5", 4'd5, 3, 5, 0, 0, 0, 0);
        k("ed_pin_second", 4'd6, 3, 5, 0, 1, 0, 0);
        k("ed_pin_illegal_F", 4'hF, 3, 5, 0, 1, 0, 0);
        k("ed_pin_clear", 4'hA, 3, 0, 0, 0, 0, 0);
        k("ed_pin7", 4'd7, 3, 7, 0, 0, 0, 0);
        rst("ed_reset_mid_pin");
        k("ed_enter_after_reset", 4'hB, 0, 0, 0, 1, 0, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // ACC-state inactivity: a full idle window expires
        vecs.delete();
        k("to_k2", 4'd2, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < T - 1; i++) idle("to_idle", 1'b0, 2, 0, 0, 0, 0, 0);
        idle("to_expire", 1'b0, 0, 0, 0, 1, 0, 0);
        idle("to_pulse_end", 1'b0, 0, 0, 0, 0, 0, 0);
        // A key on the final idle cycle wins and restarts the window
        k("to2_k2", 4'd2, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < T - 1; i++) idle("to2_idle", 1'b0, 2, 0, 0, 0, 0, 0);
        k("to2_key_last_cycle", 4'd3, 23, 0, 0, 0, 0, 0);
        for (int i = 0; i < T - 1; i++) idle("to2_idle_again", 1'b0, 23, 0, 0, 0, 0, 0);
        idle("to2_expire", 1'b0, 0, 0, 0, 1, 0, 0);
        // No counting in ACC with an empty entry
        for (int i = 0; i < 3 * T; i++) idle("to_empty_acc", 1'b0, 0, 0, 0, 0, 0, 0);
        foreach (vecs[i]) run_vec(vecs[i]);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries still queued, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
- Upstream front-end of the ATM controller.
- Turns a stream of single keypad key events into one complete credential: a 12-bit account number and a 4-bit PIN digit.
- Presents the credential to the authentication/controller stage through a valid/ready handshake, then waits for that stage's verdict.
- Counts consecutive failed attempts, locks the keypad after MAX_FAILS, and abandons partial entries after an inactivity timeout.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles allowed during entry before the partial entry is discarded.
- MAX_FAILS, 3: consecutive auth failures that cause lockout.
- ACC_DIGITS, 4: maximum decimal digits accepted for the account number.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous reset, active-low.
- key_valid  in  1  one-cycle strobe; key_code is valid in this cycle.
- key_code  in  4  0-9 = digit, A = CLEAR, B = ENTER, C = CANCEL, D-F = illegal.
- out_ready  in  1  downstream accepts the credential.
- auth_done  in  1  one-cycle strobe carrying the downstream verdict.
- auth_ok  in  1  verdict, qualified by auth_done: 1 = authenticated.
- accNumber  out  12  assembled account number (binary).
- pin  out  4  assembled PIN digit.
- out_valid  out  1  credential is presented.
- key_err  out  1  one-cycle pulse: a key was rejected.
- timeout  out  1  one-cycle pulse: entry abandoned on inactivity.
- locked  out  1  lockout active.
- fail_cnt  out  2  consecutive failure count.

Behaviour:
- Reset: reset_n low at a clk edge forces state ACC. All outputs go to 0: accNumber, pin, out_valid, key_err, timeout, locked, fail_cnt. Internal digit count, pin_set flag and idle counter also clear. Reset overrides every state, including mid-handshake and LOCKED.
- Key timing: a key is acted on at the edge where key_valid=1. key_err and timeout are registered and assert in the following cycle for exactly one cycle.
- Illegal codes (D-F): key_err pulses; no other change, in any state.
- State ACC (account entry):
  - Digit d, with count < ACC_DIGITS and accNumber*10+d <= 4095: accNumber <= accNumber*10+d; count++.
  - Digit otherwise: key_err pulses; accNumber is unchanged.
  - The product is computed at 16 bits before the compare.
  - CLEAR: accNumber=0, count=0.
  - ENTER with count=0: key_err. ENTER with count>0: go to PIN.
  - CANCEL: accNumber=0, count=0; stay in ACC.
- State PIN (PIN entry):
  - Digit with pin_set=0: pin=d, pin_set=1.
  - Digit with pin_set=1: key_err.
  - CLEAR: pin=0, pin_set=0.
  - ENTER with pin_set=0: key_err. ENTER with pin_set=1: go to PRESENT.
  - CANCEL: clear accNumber, pin and count; go to ACC.
- State PRESENT:
  - out_valid=1 starting the cycle after the accepting ENTER.
  - accNumber and pin are held stable while out_valid=1.
  - Transfer happens at an edge with out_valid & out_ready; go to WAIT, and out_valid drops the next cycle.
  - Any key in this state: key_err.
  - Unlimited backpressure; no timeout in this state.
- State WAIT:
  - Keys give key_err. auth_done is acted on only in this state and is ignored elsewhere.
  - auth_ok=1: fail_cnt=0; clear accNumber, pin and count; go to ACC.
  - auth_ok=0, fail_cnt+1 < MAX_FAILS: fail_cnt++; keep accNumber; clear pin and pin_set; go to PIN.
  - auth_ok=0, fail_cnt+1 = MAX_FAILS: fail_cnt++; locked=1; go to LOCKED.
- State LOCKED: terminal until reset_n. Keys give key_err. Outputs hold their values.
- Idle timeout:
  - The idle counter runs only in ACC with count>0, or in PIN. It resets on any key_valid and on every state change.
  - When the counter reaches TIMEOUT_CYCLES-1: timeout pulse; clear accNumber, pin, count and pin_set; go to ACC. fail_cnt is not cleared.
  - If key_valid arrives in the same cycle, the key wins and the counter restarts.
- No other simultaneity is possible: auth_done and out_ready are only meaningful in disjoint states.

Test Plan:
- Normal login: keys 2,7,4,9,B,0,B with out_ready=1 -> out_valid=1 with accNumber=2749, pin=0. Then auth_done=1, auth_ok=1 -> state ACC, accNumber=0, fail_cnt=0.
- Width limit: keys 4,0,9,6 -> key_err on the 6th key's following cycle (4096 > 4095), accNumber=409. A 5th digit after 2,1,7,5 -> key_err, accNumber=2175.
- Backpressure: reach PRESENT with acc 2125, pin 3, out_ready=0 for 5 cycles -> out_valid and values held. Raise out_ready -> out_valid low the next cycle, state WAIT.
- Lockout: three logins on acc 2178 with pin 9, each answered auth_ok=0 -> fail_cnt goes 1, 2, 3. The first two return to PIN with accNumber=2178. The third sets locked=1, and later keys give key_err. reset_n low -> everything clears.
- Timeout: key 2, then idle TIMEOUT_CYCLES cycles -> timeout pulse, accNumber=0. A key on the final cycle instead -> no timeout.
- Editing/reset: 2,9,A,2,6,4,7,B,C -> ACC with accNumber=0. reset_n low mid-PIN -> all outputs 0 the next cycle.
